// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the NoC reduce endpoint:
//   - default AXI-Stream field widths used on the mesh
//   - the AXI-Stream flit bundle (data, last, id, dest) at default widths
//   - the reduce FSM state encoding
// No ports (package).
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int NOC_TDATAW = 32;
    localparam int NOC_TDESTW = 4;
    localparam int NOC_TIDW   = 2;

    // One mesh flit at the default widths.
    typedef struct packed {
        logic [NOC_TDATAW-1:0] data;
        logic                  last;
        logic [NOC_TIDW-1:0]   id;
        logic [NOC_TDESTW-1:0] dest;
    } axis_flit_t;

    // IDLE: wait for one operand from every source, pop them and register the sum.
    // SUM : load the master output registers from the registered sum.
    // SEND: hold the result flit until the downstream handshake.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_SEND = 2'd2
    } reduce_state_t;

endpackage

// File: rtl/noc_op_fifo.sv
// -----------------------------------------------------------------------------
// noc_op_fifo
// Synchronous single-clock operand FIFO with a flush input. The head entry is
// always visible on 'head' (first-word fall-through), so the consumer can use
// it in the same cycle it pops.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset (empties the FIFO)
//   flush      in   synchronous flush (empties the FIFO), wins over push/pop
//   push       in   write push_data (ignored when full)
//   push_data  in   [DW] data written on push
//   pop        in   discard the head entry (ignored when empty)
//   head       out  [DW] current head entry
//   empty      out  no entries stored
//   full       out  DEPTH entries stored
// -----------------------------------------------------------------------------
module noc_op_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/noc_reduce_node.sv
// -----------------------------------------------------------------------------
// noc_reduce_node
// Mesh endpoint that collects one operand from each of NUM_SRC producers,
// reduces them to one unsigned sum and sends the result as a single-flit
// AXI-Stream packet (TLAST=1, TID=NODE_ID, TDEST=RESULT_DEST).
//
// The incoming TID selects the operand slot; each slot has its own FIFO of
// depth OP_DEPTH so operand k of every source forms result k. Flits whose TID
// is not a valid slot are accepted and discarded (DROP_CNT counts them).
//
// Build option:
//   NOC_REDUCE_SAT_EN  defined   -> saturating sum (all-ones on overflow)
//                      undefined -> wrap-around sum (low TDATAW bits)
//
// Handshake rule on both AXI-Stream ports: a transfer happens on a rising CLK
// edge where TVALID and TREADY are both high; a master holds its flit stable
// while TVALID is high and TREADY is low, and TVALID never waits for TREADY.
//
// Ports:
//   CLK            in   clock
//   RST_N          in   synchronous active-low reset
//   CLEAR          in   synchronous flush of FIFOs and result path; counters kept
//   BUSY           out  any operand stored or a result in flight
//   RESULT_CNT     out  [16] results accepted downstream (wraps)
//   DROP_CNT       out  [16] flits discarded for invalid TID (saturates)
//   AXIS_S_*       slave side from the mesh (TLAST/TDEST ignored)
//   AXIS_M_*       master side to the mesh
// -----------------------------------------------------------------------------
module noc_reduce_node
    import noc_pkg::*;
#(
    parameter int TDATAW      = NOC_TDATAW,
    parameter int TDESTW      = NOC_TDESTW,
    parameter int TIDW        = NOC_TIDW,
    parameter int NUM_SRC     = 2,
    parameter int OP_DEPTH    = 4,
    parameter int RESULT_DEST = 3,
    parameter int NODE_ID     = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic [15:0]       RESULT_CNT,
    output logic [15:0]       DROP_CNT,

    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TIDW-1:0]   AXIS_S_TID,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,

    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TIDW-1:0]   AXIS_M_TID,
    output logic [TDESTW-1:0] AXIS_M_TDEST
);

    // Wide enough that the sum of NUM_SRC full-scale operands never overflows.
    localparam int SUMW = TDATAW + $clog2(NUM_SRC);

    reduce_state_t state;

    logic [NUM_SRC-1:0] fifo_empty;
    logic [NUM_SRC-1:0] fifo_full;
    logic [NUM_SRC-1:0] fifo_push;
    logic [TDATAW-1:0]  fifo_head [NUM_SRC];
    logic               fifo_pop;

    logic [NUM_SRC-1:0] tid_hit;
    logic               tid_valid;
    logic               slot_full;
    logic               s_ready;
    logic               s_fire;
    logic               drop_fire;
    logic               all_ready;
    logic               m_fire;

    logic [SUMW-1:0]    sum_wide;
    logic [TDATAW-1:0]  sum_res;
    logic [TDATAW-1:0]  result_q;

    logic               m_valid;
    logic [TDATAW-1:0]  m_data;
    logic               m_last;
    logic [TIDW-1:0]    m_id;
    logic [TDESTW-1:0]  m_dest;
    logic [15:0]        result_cnt;
    logic [15:0]        drop_cnt;

    // TLAST and TDEST of incoming flits carry no meaning for this endpoint.
    logic unused_s_fields;
    assign unused_s_fields = ^{AXIS_S_TLAST, AXIS_S_TDEST};

    // ------------------------------------------------------------------
    // Slave side: decode TID into an operand slot.
    // ------------------------------------------------------------------
    always_comb begin
        tid_hit   = '0;
        tid_valid = 1'b0;
        slot_full = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (AXIS_S_TID == TIDW'(i)) begin
                tid_hit[i] = 1'b1;
                tid_valid  = 1'b1;
                slot_full  = fifo_full[i];
            end
        end
    end

    // Ready looks only at the registered full flag, so a pop in the same cycle
    // does not open a full FIFO. Invalid TIDs are always sunk. Ready is held
    // low during reset and during CLEAR so no flit is accepted only to be
    // flushed in the same edge.
    assign s_ready   = RST_N && !CLEAR && (tid_valid ? !slot_full : 1'b1);
    assign s_fire    = AXIS_S_TVALID && s_ready;
    assign fifo_push = {NUM_SRC{s_fire}} & tid_hit;
    assign drop_fire = s_fire && !tid_valid;

    // ------------------------------------------------------------------
    // Per-source operand FIFOs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        noc_op_fifo #(
            .DW    (TDATAW),
            .DEPTH (OP_DEPTH)
        ) u_fifo (
            .clk       (CLK),
            .rst_n     (RST_N),
            .flush     (CLEAR),
            .push      (fifo_push[g]),
            .push_data (AXIS_S_TDATA),
            .pop       (fifo_pop),
            .head      (fifo_head[g]),
            .empty     (fifo_empty[g]),
            .full      (fifo_full[g])
        );
    end

    assign all_ready = &(~fifo_empty);
    assign fifo_pop  = (state == ST_IDLE) && all_ready && !CLEAR;

    // ------------------------------------------------------------------
    // Reduction of the FIFO heads
    // ------------------------------------------------------------------
    always_comb begin
        sum_wide = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sum_wide = sum_wide + SUMW'(fifo_head[i]);
        end
    end

`ifdef NOC_REDUCE_SAT_EN
    // Any carry into the extension bits means the true sum exceeds TDATAW bits.
    assign sum_res = (|sum_wide[SUMW-1:TDATAW]) ? {TDATAW{1'b1}} : sum_wide[TDATAW-1:0];
`else
    // Wrap-around: the carry bits are simply discarded.
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum_wide[SUMW-1:TDATAW];
    assign sum_res       = sum_wide[TDATAW-1:0];
`endif

    // ------------------------------------------------------------------
    // Reduce FSM with registered master outputs
    // ------------------------------------------------------------------
    assign m_fire = m_valid && AXIS_M_TREADY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            result_q <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            m_id     <= '0;
            m_dest   <= '0;
        end else if (CLEAR) begin
            // Abandon any result in flight, including one already on the bus.
            state   <= ST_IDLE;
            m_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (all_ready) begin
                        result_q <= sum_res;
                        state    <= ST_SUM;
                    end
                end
                ST_SUM: begin
                    m_valid <= 1'b1;
                    m_data  <= result_q;
                    m_last  <= 1'b1;
                    m_id    <= TIDW'(NODE_ID);
                    m_dest  <= TDESTW'(RESULT_DEST);
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (AXIS_M_TREADY) begin
                        m_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status counters (survive CLEAR, cleared by reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            result_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            // A handshake that coincides with CLEAR still completed on the bus.
            if (m_fire) begin
                result_cnt <= result_cnt + 16'd1;
            end
            if (drop_fire && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign BUSY          = (|(~fifo_empty)) || (state != ST_IDLE);
    assign RESULT_CNT    = result_cnt;
    assign DROP_CNT      = drop_cnt;
    assign AXIS_S_TREADY = s_ready;
    assign AXIS_M_TVALID = m_valid;
    assign AXIS_M_TDATA  = m_data;
    assign AXIS_M_TLAST  = m_last;
    assign AXIS_M_TID    = m_id;
    assign AXIS_M_TDEST  = m_dest;

endmodule
